// File: rtl/qracc_wsram_responder.sv
// qracc_wsram_responder
//   Responder for the controller's weight-SRAM request channel. Holds numBanks
//   single-port banks of numRows x dataWidth words, zero-sweeps every row after
//   reset or clear, then accepts one read or write per cycle under valid/ready.
//   Read data returns one cycle after acceptance.
//
// Ports
//   clk            in   clock
//   nrst           in   asynchronous active-low reset
//   clear_i        in   synchronous re-initialise request
//   rq_valid_i     in   request valid
//   rq_wr_i        in   1 = write, 0 = read
//   addr_i         in   row address
//   wr_data_i      in   write data
//   bank_select_i  in   bank mask (writes: all set banks; reads: lowest set bank)
//   rq_ready_o     out  request can be accepted (from state and clear_i only)
//   rd_valid_o     out  one-cycle read data valid pulse
//   rd_data_o      out  read data, held while rd_valid_o is low
//   init_done_o    out  zero sweep completed
//   wr_count_o     out  saturating count of accepted writes since reset/clear
module qracc_wsram_responder #(
    parameter int numRows   = 256,
    parameter int numBanks  = 8,
    parameter int dataWidth = 32,
    localparam int addrBits = $clog2(numRows)
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic                 clear_i,
    input  logic                 rq_valid_i,
    input  logic                 rq_wr_i,
    input  logic [addrBits-1:0]  addr_i,
    input  logic [dataWidth-1:0] wr_data_i,
    input  logic [numBanks-1:0]  bank_select_i,
    output logic                 rq_ready_o,
    output logic                 rd_valid_o,
    output logic [dataWidth-1:0] rd_data_o,
    output logic                 init_done_o,
    output logic [31:0]          wr_count_o
);

    localparam int bank_bits = (numBanks > 1) ? $clog2(numBanks) : 1;

    localparam logic [0:0] S_INIT  = 1'b0;
    localparam logic [0:0] S_READY = 1'b1;

    logic [0:0]           state;
    logic [addrBits-1:0]  init_row;
    logic                 wr_accept;
    logic                 rd_accept;
    logic [bank_bits-1:0] rd_bank;
    logic                 rd_any;

    logic [dataWidth-1:0] mem [numBanks][numRows];

    // Ready never looks at rq_valid_i, so the controller cannot close a
    // combinational loop through this handshake.
    assign rq_ready_o = (state == S_READY) && !clear_i;
    assign wr_accept  = rq_valid_i && rq_ready_o && rq_wr_i;
    assign rd_accept  = rq_valid_i && rq_ready_o && !rq_wr_i;
    assign rd_any     = |bank_select_i;

    // Lowest-index set bit wins: scan from the top so lower banks overwrite.
    // NOTE: rd_bank gets a default before the loop so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        rd_bank = '0;
        for (int b = numBanks - 1; b >= 0; b--) begin
            if (bank_select_i[b]) rd_bank = bank_bits'(b);
        end
    end

    // Control state, sweep counter and write counter. Clear outranks
    // everything except reset and blocks acceptance through rq_ready_o.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state       <= S_INIT;
            init_row    <= '0;
            init_done_o <= 1'b0;
            wr_count_o  <= '0;
        end else if (clear_i) begin
            state       <= S_INIT;
            init_row    <= '0;
            init_done_o <= 1'b0;
            wr_count_o  <= '0;
        end else begin
            if (state == S_INIT) begin
                init_row <= init_row + addrBits'(1);
                if (init_row == addrBits'(numRows - 1)) begin
                    state       <= S_READY;
                    init_done_o <= 1'b1;
                end
            end
            if (wr_accept && (wr_count_o != '1)) begin
                wr_count_o <= wr_count_o + 32'd1;
            end
        end
    end

    // Read return path. A read accepted just before a clear still completes
    // because the capture happens on the acceptance edge.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rd_valid_o <= 1'b0;
            rd_data_o  <= '0;
        end else begin
            rd_valid_o <= rd_accept;
            if (rd_accept) begin
                rd_data_o <= rd_any ? mem[rd_bank][addr_i] : '0;
            end
        end
    end

    // Array write port: the zero sweep during S_INIT, otherwise accepted
    // writes to every selected bank. A zero mask touches nothing.
    // NOTE: the array has no reset; its contents are defined by the sweep,
    // which keeps it mappable onto real SRAM macros.
    always_ff @(posedge clk) begin
        for (int b = 0; b < numBanks; b++) begin
            if (state == S_INIT) begin
                mem[b][init_row] <= '0;
            end else if (wr_accept && bank_select_i[b]) begin
                mem[b][addr_i] <= wr_data_i;
            end
        end
    end

endmodule

// File: tb/tb_qracc_wsram_responder.sv
module tb_qracc_wsram_responder;

    localparam int NR = 256;
    localparam int NB = 8;
    localparam int DW = 32;
    localparam int AB = 8;

    logic          clk = 1'b0;
    logic          nrst;
    logic          clear_i;
    logic          rq_valid_i;
    logic          rq_wr_i;
    logic [AB-1:0] addr_i;
    logic [DW-1:0] wr_data_i;
    logic [NB-1:0] bank_select_i;
    logic          rq_ready_o;
    logic          rd_valid_o;
    logic [DW-1:0] rd_data_o;
    logic          init_done_o;
    logic [31:0]   wr_count_o;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] sb [$];

    qracc_wsram_responder #(.numRows(NR), .numBanks(NB), .dataWidth(DW)) dut (
        .clk           (clk),
        .nrst          (nrst),
        .clear_i       (clear_i),
        .rq_valid_i    (rq_valid_i),
        .rq_wr_i       (rq_wr_i),
        .addr_i        (addr_i),
        .wr_data_i     (wr_data_i),
        .bank_select_i (bank_select_i),
        .rq_ready_o    (rq_ready_o),
        .rd_valid_o    (rd_valid_o),
        .rd_data_o     (rd_data_o),
        .init_done_o   (init_done_o),
        .wr_count_o    (wr_count_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every read-valid pulse is matched against the oldest expected read.
    always @(negedge clk) begin
        if (rd_valid_o) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_unexpected: got rd_valid with data 0x%08h, expected no read at %0t",
                         rd_data_o, $time);
            end else begin
                check("rd_data", rd_data_o, sb.pop_front());
            end
        end
    end

    // Issue one request; inputs change #1 after a rising edge.
    task automatic req(input logic wr, input int a, input logic [31:0] d,
                       input logic [7:0] m, input logic [31:0] exp);
        rq_valid_i    = 1'b1;
        rq_wr_i       = wr;
        addr_i        = AB'(a);
        wr_data_i     = d;
        bank_select_i = m;
        #1;
        check("req_ready", {31'd0, rq_ready_o}, 32'd1);
        if (!wr) sb.push_back(exp);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        rq_valid_i = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Expects the sweep to start at the next rising edge.
    task automatic wait_init();
        int low = 0;
        for (int k = 1; k < NR; k++) begin
            @(posedge clk);
            #1;
            if (!rq_ready_o && !init_done_o) low++;
        end
        check("init_low_cycles", low, NR - 1);
        @(posedge clk);
        #1;
        check("init_ready", {31'd0, rq_ready_o}, 32'd1);
        check("init_done", {31'd0, init_done_o}, 32'd1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ready"}, {31'd0, rq_ready_o}, 32'd0);
        check({tag, "_rd_valid"}, {31'd0, rd_valid_o}, 32'd0);
        check({tag, "_rd_data"}, rd_data_o, 32'd0);
        check({tag, "_init_done"}, {31'd0, init_done_o}, 32'd0);
        check({tag, "_wr_count"}, wr_count_o, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        nrst          = 1'b0;
        clear_i       = 1'b0;
        rq_valid_i    = 1'b0;
        rq_wr_i       = 1'b0;
        addr_i        = '0;
        wr_data_i     = '0;
        bank_select_i = '0;
        #23;
        check_reset_values("reset");
        @(negedge clk);
        nrst = 1'b1;
        wait_init();

        // Post-sweep defaults: all banks read zero at both ends of the array.
        for (int b = 0; b < NB; b++) begin
            req(1'b0, 0, 32'd0, 8'(1 << b), 32'd0);
            req(1'b0, NR - 1, 32'd0, 8'(1 << b), 32'd0);
        end
        idle(2);

        // Burst fill, then read every entry back-to-back.
        for (int i = 0; i < 2048; i++) req(1'b1, i >> 3, 32'(i), 8'(1 << (i & 7)), 32'd0);
        check("burst_wr_count", wr_count_o, 32'd2048);
        for (int i = 0; i < 2048; i++) req(1'b0, i >> 3, 32'd0, 8'(1 << (i & 7)), 32'(i));
        idle(2);

        // Write immediately followed by read of the same word; data then holds.
        req(1'b1, 5, 32'hDEADBEEF, 8'h01, 32'd0);
        req(1'b0, 5, 32'd0, 8'h01, 32'hDEADBEEF);
        idle(1);
        check("hold_rd_valid", {31'd0, rd_valid_o}, 32'd0);
        check("hold_rd_data", rd_data_o, 32'hDEADBEEF);

        // Multi-hot write, lowest-bank read selection, zero-mask handling.
        req(1'b1, 10, 32'h12, 8'hA0, 32'd0);
        req(1'b0, 10, 32'd0, 8'h80, 32'h12);
        req(1'b1, 10, 32'h77, 8'h80, 32'd0);
        req(1'b0, 10, 32'd0, 8'hA0, 32'h12);   // bank 5
        req(1'b0, 10, 32'd0, 8'hC0, 32'd86);   // bank 6 from burst
        req(1'b0, 10, 32'd0, 8'h00, 32'd0);
        req(1'b1, 10, 32'h55, 8'h00, 32'd0);
        req(1'b0, 10, 32'd0, 8'h01, 32'd80);   // untouched by zero-mask write
        idle(1);
        check("mask_wr_count", wr_count_o, 32'd2052);

        // Clear right after an accepted read: read still returns, new one refused.
        req(1'b0, 10, 32'd0, 8'h80, 32'h77);
        clear_i = 1'b1;
        rq_valid_i = 1'b1;
        rq_wr_i = 1'b0;
        addr_i = 8'd10;
        bank_select_i = 8'h80;
        #1;
        check("clear_ready", {31'd0, rq_ready_o}, 32'd0);
        @(posedge clk);
        #1;
        clear_i = 1'b0;
        rq_valid_i = 1'b0;
        check("clear_wr_count", wr_count_o, 32'd0);
        check("clear_init_done", {31'd0, init_done_o}, 32'd0);
        wait_init();
        req(1'b0, 10, 32'd0, 8'h20, 32'd0);
        req(1'b0, 10, 32'd0, 8'h80, 32'd0);
        req(1'b0, 5, 32'd0, 8'h01, 32'd0);
        idle(1);

        // Reset in the middle of a sweep restarts it from row 0.
        clear_i = 1'b1;
        @(posedge clk);
        #1;
        clear_i = 1'b0;
        repeat (100) @(posedge clk);
        #2;
        nrst = 1'b0;
        #1;
        check_reset_values("midreset");
        @(negedge clk);
        nrst = 1'b1;
        wait_init();
        req(1'b1, 200, 32'hCAFE0001, 8'h10, 32'd0);
        req(1'b0, 200, 32'd0, 8'h10, 32'hCAFE0001);
        req(1'b0, 200, 32'd0, 8'h08, 32'd0);
        idle(3);
        check("post_wr_count", wr_count_o, 32'd1);
        check("scoreboard_empty", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
